pc_sequencer: RTL

Sequential controller for the processor's next-PC datapath. It owns the program counter register, runs the instruction-fetch handshake with instruction memory, and, once per retired instruction, selects the next PC from sequential (PC+4), branch target or jump target. It sits between the control unit and instruction memory and sequences the 32-bit next-PC selection that feeds the PC register.

---
 rtl/pc_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: owns the PC, runs the fetch handshake and picks PC+4 / branch / jump once per retire.
// Optional PC_SEQ_ALIGN_CHECK_EN: misaligned redirect targets trap to TRAP_VECTOR and pulse fault.
//
// state | meaning
// IDLE  | post-reset, no fetch outstanding
// FETCH | imem_req high, waiting for imem_ack
// ISSUE | instruction presented; retires on the first cycle without stall
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] instret,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        retire;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic [31:0] instret_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = imem_ack ? ISSUE : FETCH;
            ISSUE:   state_nxt = stall ? ISSUE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == ISSUE);
    end

    assign retire      = (state == ISSUE) && !stall;
    assign redirect    = jump || branch_taken;
    assign target      = jump ? jump_target : branch_target;
    assign instret_inc = instret + 32'd1;
    assign imem_addr   = pc;

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic misalign;

    assign misalign = redirect && (target[1:0] != 2'b00);

    always_comb begin
        next_pc = pc + 32'd4;
        if (misalign) begin
            next_pc = TRAP_VECTOR;
        end else if (redirect) begin
            next_pc = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault <= 1'b0;
        end else begin
            fault <= retire && misalign;
        end
    end
`else
    // Without the check, low address bits of a redirect are simply dropped.
    always_comb begin
        next_pc = pc + 32'd4;
        if (redirect) begin
            next_pc = target & 32'hFFFF_FFFC;
        end
    end

    assign fault = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VECTOR;
            instret <= 32'd0;
        end else if (retire) begin
            pc      <= next_pc;
            instret <= instret_inc;
        end
    end

endmodule
